// File: rtl/dmem_port_arbiter.sv
// Two-requester arbiter for the single-port data memory: core MEM stage vs debug/loader.
// One transaction in flight at a time; reads return data with a one-cycle rvalid pulse.
module dmem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  // WAIT runs RD_LAT-1 down to 0; only meaningful when RD_LAT >= 1.
  localparam logic [1:0] CNT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              owner_q, owner_d;   // 1 = dbg owns the transaction
  logic              last_q, last_d;     // 1 = dbg was granted last
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] core_rdata_q, core_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              pick_dbg;

  // dbg wins when alone, or on a tie in round-robin mode when core went last.
  assign pick_dbg = dbg_req && (!core_req || ((PRIO_MODE == 0) && !last_q));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    owner_d      = owner_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    core_rdata_d = core_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    core_gnt     = 1'b0;
    dbg_gnt      = 1'b0;
    core_rvalid  = 1'b0;
    dbg_rvalid   = 1'b0;
    mem_we       = 1'b0;
    case (state_q)
      IDLE: begin
        if ((core_req || dbg_req) && !rst) begin
          core_gnt = !pick_dbg;
          dbg_gnt  = pick_dbg;
          addr_d   = pick_dbg ? dbg_addr  : core_addr;
          wdata_d  = pick_dbg ? dbg_wdata : core_wdata;
          we_d     = pick_dbg ? dbg_we    : core_we;
          owner_d  = pick_dbg;
          last_d   = pick_dbg;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          mem_we  = 1'b1;
          state_d = IDLE;
        end else if (RD_LAT == 0) begin
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         core_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         core_rdata_d = mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        core_rvalid = !owner_q;
        dbg_rvalid  = owner_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      owner_q      <= 1'b0;
      last_q       <= 1'b1;
      cnt_q        <= 2'd0;
      core_rdata_q <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      core_rdata_q <= core_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign core_rdata = core_rdata_q;
  assign dbg_rdata  = dbg_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: four instances (RD_LAT 1/0/3 round-robin, RD_LAT 1 fixed priority)
// checked every cycle against a transaction-timeline reference model.
module tb_dmem_port_arbiter;
  localparam int NI = 4;

  function automatic int lat_of(input int k);
    return (k == 1) ? 0 : (k == 2) ? 3 : 1;
  endfunction
  function automatic int prio_of(input int k);
    return (k == 3) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic        core_req[NI], core_we[NI], core_gnt[NI], core_rvalid[NI];
  logic [31:0] core_addr[NI], core_wdata[NI], core_rdata[NI];
  logic        dbg_req[NI], dbg_we[NI], dbg_gnt[NI], dbg_rvalid[NI];
  logic [31:0] dbg_addr[NI], dbg_wdata[NI], dbg_rdata[NI];
  logic [31:0] mem_addr[NI], mem_wdata[NI], mem_rdata[NI];
  logic        mem_we[NI], busy[NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32),
      .RD_LAT((g == 1) ? 0 : (g == 2) ? 3 : 1),
      .PRIO_MODE((g == 3) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .core_req(core_req[g]), .core_we(core_we[g]), .core_addr(core_addr[g]),
      .core_wdata(core_wdata[g]), .core_gnt(core_gnt[g]), .core_rvalid(core_rvalid[g]),
      .core_rdata(core_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_gnt(dbg_gnt[g]), .dbg_rvalid(dbg_rvalid[g]),
      .dbg_rdata(dbg_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_we(mem_we[g]),
      .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit keep_req = 1'b0;
  logic rst_v;

  // Requester intent, index [instance][0=core,1=dbg]
  logic        rq[NI][2], rwe[NI][2];
  logic [31:0] rad[NI][2], rwd[NI][2];

  // Reference model: memory image plus the timeline of the transaction in flight
  logic [31:0] mem[NI][16];
  int          free_cyc[NI], wr_cyc[NI], cap_cyc[NI], rv_cyc[NI];
  logic [3:0]  cap_idx[NI];
  logic        own_dbg[NI], last_dbg[NI];
  logic [31:0] cur_addr[NI], cur_wdata[NI], cap_data[NI], exp_rd[NI][2];

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[%0d]: observed 0x%h expected 0x%h at cycle %0d", tag, k, obs, exp, cyc);
    end
  endtask

  task automatic chk1(input string tag, input int k, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s[%0d]: observed %b expected %b at cycle %0d", tag, k, obs, exp, cyc);
    end
  endtask

  task automatic model_reset(input int k);
    free_cyc[k] = cyc + 1;
    wr_cyc[k]   = -1;
    cap_cyc[k]  = -1;
    rv_cyc[k]   = -1;
    last_dbg[k] = 1'b1;
    own_dbg[k]  = 1'b0;
    cur_addr[k] = '0;
    cur_wdata[k] = '0;
    exp_rd[k][0] = '0;
    exp_rd[k][1] = '0;
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance the model.
  task automatic tick();
    logic g_c, g_d, w, busy_e;
    int   lat;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = rst_v;
    for (int k = 0; k < NI; k++) begin
      core_req[k]   = rq[k][0] && !rst_v;
      core_we[k]    = rwe[k][0];
      core_addr[k]  = rad[k][0];
      core_wdata[k] = rwd[k][0];
      dbg_req[k]    = rq[k][1] && !rst_v;
      dbg_we[k]     = rwe[k][1];
      dbg_addr[k]   = rad[k][1];
      dbg_wdata[k]  = rwd[k][1];
      if (cyc == cap_cyc[k]) begin
        cap_data[k]  = mem[k][cap_idx[k]];
        mem_rdata[k] = cap_data[k];
      end else begin
        mem_rdata[k] = $urandom();
      end
    end
    #1;
    for (int k = 0; k < NI; k++) begin
      lat    = lat_of(k);
      busy_e = (cyc < free_cyc[k]);
      g_c = 1'b0;
      g_d = 1'b0;
      w   = 1'b0;
      if (!rst_v && !busy_e && (rq[k][0] || rq[k][1])) begin
        if (rq[k][0] && rq[k][1]) w = (prio_of(k) == 1) ? 1'b0 : !last_dbg[k];
        else                      w = rq[k][1];
        g_c = !w;
        g_d = w;
      end
      if (cyc == rv_cyc[k]) exp_rd[k][own_dbg[k]] = cap_data[k];
      if (chk_en) begin
        chk1("core_gnt", k, core_gnt[k], g_c);
        chk1("dbg_gnt", k, dbg_gnt[k], g_d);
        chk1("busy", k, busy[k], busy_e);
        chk1("mem_we", k, mem_we[k], cyc == wr_cyc[k]);
        chk("mem_addr", k, mem_addr[k], cur_addr[k]);
        chk("mem_wdata", k, mem_wdata[k], cur_wdata[k]);
        chk1("core_rvalid", k, core_rvalid[k], (cyc == rv_cyc[k]) && !own_dbg[k]);
        chk1("dbg_rvalid", k, dbg_rvalid[k], (cyc == rv_cyc[k]) && own_dbg[k]);
        chk("core_rdata", k, core_rdata[k], exp_rd[k][0]);
        chk("dbg_rdata", k, dbg_rdata[k], exp_rd[k][1]);
      end
      if (g_c || g_d) begin
        last_dbg[k]  = w;
        own_dbg[k]   = w;
        cur_addr[k]  = rad[k][w];
        cur_wdata[k] = rwd[k][w];
        if (rwe[k][w]) begin
          wr_cyc[k]   = cyc + 1;
          free_cyc[k] = cyc + 2;
          mem[k][rad[k][w][5:2]] = rwd[k][w];
        end else begin
          cap_cyc[k]  = cyc + 1 + lat;
          rv_cyc[k]   = cyc + 2 + lat;
          free_cyc[k] = cyc + 3 + lat;
          cap_idx[k]  = rad[k][w][5:2];
        end
        if (!keep_req) rq[k][w] = 1'b0;
      end
      if (rst_v) model_reset(k);
    end
  endtask

  task automatic set_req(input int k, input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
    rq[k][p]  = 1'b1;
    rwe[k][p] = we;
    rad[k][p] = a;
    rwd[k][p] = d;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_reqs();
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!rq[k][p]) begin
          if ($urandom_range(0, 2) == 0)
            set_req(k, p, 1'($urandom_range(0, 1)), $urandom(), $urandom());
        end else if ($urandom_range(0, 19) == 0) begin
          rq[k][p] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int gcnt0, gcnt3;
    logic exp_dbg;
    rst   = 1'b1;
    rst_v = 1'b1;
    for (int k = 0; k < NI; k++) begin
      for (int p = 0; p < 2; p++) begin
        rq[k][p] = 1'b0; rwe[k][p] = 1'b0; rad[k][p] = '0; rwd[k][p] = '0;
      end
      for (int i = 0; i < 16; i++) mem[k][i] = $urandom();
      core_req[k] = 1'b0; core_we[k] = 1'b0; core_addr[k] = '0; core_wdata[k] = '0;
      dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
      mem_rdata[k] = '0;
      cap_idx[k] = '0;
      cap_data[k] = '0;
      model_reset(k);
    end

    // Reset, then reset state
    idle_ticks(3);
    rst_v  = 1'b0;
    chk_en = 1'b1;
    tick();
    chk1("rst_busy", 0, busy[0], 1'b0);
    chk("rst_mem_addr", 0, mem_addr[0], 32'h0);
    chk("rst_core_rdata", 0, core_rdata[0], 32'h0);

    // Core write then read on RD_LAT=1
    set_req(0, 0, 1'b1, 32'h10, 32'hDEADBEEF);
    tick();
    chk1("wr_gnt_T", 0, core_gnt[0], 1'b1);
    chk1("wr_we_T", 0, mem_we[0], 1'b0);
    tick();
    chk1("wr_we_T1", 0, mem_we[0], 1'b1);
    chk("wr_addr_T1", 0, mem_addr[0], 32'h10);
    chk("wr_data_T1", 0, mem_wdata[0], 32'hDEADBEEF);
    set_req(0, 0, 1'b0, 32'h10, 32'h0);
    tick();
    chk1("wr_busy_T2", 0, busy[0], 1'b0);
    chk1("wr_we_T2", 0, mem_we[0], 1'b0);
    chk1("rd_gnt_T", 0, core_gnt[0], 1'b1);
    idle_ticks(2);
    chk1("rd_rvalid_T2", 0, core_rvalid[0], 1'b0);
    tick();
    chk1("rd_rvalid_T3", 0, core_rvalid[0], 1'b1);
    chk("rd_rdata_T3", 0, core_rdata[0], 32'hDEADBEEF);
    chk1("rd_dbg_rvalid", 0, dbg_rvalid[0], 1'b0);
    tick();

    // Continuous contention: round-robin (inst 0) vs fixed priority (inst 3)
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    keep_req = 1'b1;
    for (int k = 0; k < NI; k += 3) begin
      set_req(k, 0, 1'b0, 32'h100, 32'h0);
      set_req(k, 1, 1'b0, 32'h204, 32'h0);
    end
    gcnt0 = 0;
    gcnt3 = 0;
    exp_dbg = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (core_gnt[0] || dbg_gnt[0]) begin
        chk1("rr_order", 0, dbg_gnt[0], exp_dbg);
        exp_dbg = !exp_dbg;
        gcnt0++;
      end
      if (core_gnt[3] || dbg_gnt[3]) begin
        chk1("prio_core", 3, dbg_gnt[3], 1'b0);
        gcnt3++;
      end
    end
    chk("rr_grants", 0, gcnt0, 6);
    chk("prio_grants", 3, gcnt3, 6);
    keep_req = 1'b0;
    for (int k = 0; k < NI; k++) begin rq[k][0] = 1'b0; rq[k][1] = 1'b0; end
    idle_ticks(6);

    // Read latency 0 (inst 1) and 3 (inst 2)
    set_req(1, 0, 1'b0, 32'hABCD0128, 32'h0);
    set_req(2, 0, 1'b0, 32'hABCD0128, 32'h0);
    tick();
    chk1("lat_gnt", 1, core_gnt[1], 1'b1);
    chk1("lat_gnt", 2, core_gnt[2], 1'b1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk1("lat0_rvalid", 1, core_rvalid[1], i == 2);
      chk1("lat3_rvalid", 2, core_rvalid[2], i == 5);
      if (i == 2) chk("lat0_rdata", 1, core_rdata[1], mem[1][10]);
      if (i == 5) chk("lat3_rdata", 2, core_rdata[2], mem[2][10]);
    end
    idle_ticks(2);

    // Reset in WAIT of a dbg read (inst 2)
    set_req(2, 1, 1'b1, 32'h40, 32'hCAFEF00D);
    idle_ticks(2);
    set_req(2, 1, 1'b0, 32'h40, 32'h0);
    idle_ticks(6);
    chk("dbg_rdata_pre", 2, dbg_rdata[2], 32'hCAFEF00D);
    set_req(2, 1, 1'b0, 32'h40, 32'h0);
    tick();
    chk1("dbg_gnt", 2, dbg_gnt[2], 1'b1);
    idle_ticks(2);
    chk1("wait_busy", 2, busy[2], 1'b1);
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    tick();
    chk1("rst_busy", 2, busy[2], 1'b0);
    chk1("rst_dbg_rvalid", 2, dbg_rvalid[2], 1'b0);
    chk("rst_dbg_rdata", 2, dbg_rdata[2], 32'h0);
    set_req(2, 0, 1'b0, 32'h40, 32'h0);
    tick();
    chk1("post_rst_gnt", 2, core_gnt[2], 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1("no_dbg_rvalid", 2, dbg_rvalid[2], 1'b0);
    end

    // One-cycle dbg pulse while inst 0 is busy with a core read
    set_req(0, 0, 1'b0, 32'h80, 32'h0);
    tick();
    set_req(0, 1, 1'b1, 32'h84, 32'h12345678);
    tick();
    chk1("pulse_gnt", 0, dbg_gnt[0], 1'b0);
    rq[0][1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk1("pulse_gnt", 0, dbg_gnt[0], 1'b0);
      chk1("pulse_we", 0, mem_we[0], 1'b0);
    end

    // Randomized traffic on all instances
    for (int i = 0; i < 1500; i++) begin
      rand_reqs();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
